// File: rtl/seg7_display_reader.sv
// Loopback monitor for a two-digit active-low seven-segment bus: waits for a stable
// pattern, decodes it to BCD, flags illegal codes and breaks in the +1 mod 100 count.
module seg7_display_reader #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          CHECK_SEQ     = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_seg_ones,
  input  logic [6:0] i_seg_tens,
  input  logic       i_err_clear,
  output logic [3:0] o_bcd_ones,
  output logic [3:0] o_bcd_tens,
  output logic       o_value_valid,
  output logic       o_have_value,
  output logic [7:0] o_accept_count,
  output logic       o_pattern_error,
  output logic       o_seq_error
);

  localparam logic [3:0] STB = 4'(STABLE_CYCLES);

  // Returns {legal, digit} for the ten digit codes; anything else is illegal.
  function automatic logic [4:0] dec_digit(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Tens digit is blanked for zero; an explicit leading zero is illegal.
  function automatic logic [4:0] dec_tens(input logic [6:0] s);
    logic [4:0] r;
    if (s == 7'h7F)      r = 5'h10;
    else if (s == 7'h40) r = 5'h00;
    else                 r = dec_digit(s);
    return r;
  endfunction

  logic [6:0]  r_samp_ones, r_samp_tens, r_prev_ones, r_prev_tens;
  logic [3:0]  r_cnt;
  logic        r_last_vld;
  logic [13:0] r_last;
  logic [3:0]  r_bcd_ones, r_bcd_tens;
  logic        r_value_valid, r_have_value, r_pattern_error, r_seq_error;
  logic [7:0]  r_accept_count;

  logic [13:0] w_pat;
  logic        w_eq, w_reach, w_accept, w_legal, w_seq_bad;
  logic        w_set_perr, w_set_serr, w_legal_accept;
  logic [3:0]  w_cnt_next;
  logic [4:0]  w_dec_ones, w_dec_tens;
  logic [6:0]  w_value, w_old, w_succ;

  always_comb begin
    w_pat      = {r_samp_tens, r_samp_ones};
    w_eq       = (w_pat == {r_prev_tens, r_prev_ones});
    w_cnt_next = 4'd1;
    if (w_eq) w_cnt_next = (r_cnt == STB) ? r_cnt : r_cnt + 4'd1;
    // Only the edge where the counter arrives at STB counts; a saturated hold does not.
    w_reach    = (w_cnt_next == STB) && !(w_eq && (r_cnt == STB));
    w_accept   = w_reach && (!r_last_vld || (r_last != w_pat));
    w_dec_ones = dec_digit(r_samp_ones);
    w_dec_tens = dec_tens(r_samp_tens);
    w_legal    = w_dec_ones[4] && w_dec_tens[4];
    w_value    = {3'b000, w_dec_tens[3:0]} * 7'd10 + {3'b000, w_dec_ones[3:0]};
    w_old      = {3'b000, r_bcd_tens} * 7'd10 + {3'b000, r_bcd_ones};
    w_succ     = (w_old == 7'd99) ? 7'd0 : w_old + 7'd1;
    // A zero is always acceptable: it covers both the wrap and a transmitter restart.
    w_seq_bad  = CHECK_SEQ && r_have_value && (w_value != 7'd0) && (w_value != w_succ);
    w_legal_accept = w_accept && w_legal;
    w_set_perr = w_accept && !w_legal;
    w_set_serr = w_legal_accept && w_seq_bad;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_samp_ones     <= 7'h7F;
      r_samp_tens     <= 7'h7F;
      r_prev_ones     <= 7'h7F;
      r_prev_tens     <= 7'h7F;
      r_cnt           <= 4'd0;
      r_last_vld      <= 1'b0;
      r_last          <= 14'h0;
      r_bcd_ones      <= 4'd0;
      r_bcd_tens      <= 4'd0;
      r_value_valid   <= 1'b0;
      r_have_value    <= 1'b0;
      r_accept_count  <= 8'd0;
      r_pattern_error <= 1'b0;
      r_seq_error     <= 1'b0;
    end else begin
      r_samp_ones   <= i_seg_ones;
      r_samp_tens   <= i_seg_tens;
      r_prev_ones   <= r_samp_ones;
      r_prev_tens   <= r_samp_tens;
      r_cnt         <= w_cnt_next;
      r_value_valid <= w_legal_accept;
      if (w_accept) begin
        r_last_vld <= 1'b1;
        r_last     <= w_pat;
      end
      if (w_legal_accept) begin
        r_bcd_ones     <= w_dec_ones[3:0];
        r_bcd_tens     <= w_dec_tens[3:0];
        r_have_value   <= 1'b1;
        r_accept_count <= r_accept_count + 8'd1;
      end
      if (w_set_perr)       r_pattern_error <= 1'b1;
      else if (i_err_clear) r_pattern_error <= 1'b0;
      if (w_set_serr)       r_seq_error <= 1'b1;
      else if (i_err_clear) r_seq_error <= 1'b0;
    end
  end

  assign o_bcd_ones      = r_bcd_ones;
  assign o_bcd_tens      = r_bcd_tens;
  assign o_value_valid   = r_value_valid;
  assign o_have_value    = r_have_value;
  assign o_accept_count  = r_accept_count;
  assign o_pattern_error = r_pattern_error;
  assign o_seq_error     = r_seq_error;

endmodule

// File: tb/tb_seg7_display_reader.sv
// Bench for seg7_display_reader: directed scenarios then random segment traffic, all
// checked every cycle against a run-length reference model of the display reader.
module tb_seg7_display_reader;

  localparam int STABLE = 4;

  logic       i_clk = 1'b0;
  logic       i_rst, i_err_clear;
  logic [6:0] i_seg_ones, i_seg_tens;
  logic [3:0] o_bcd_ones, o_bcd_tens;
  logic       o_value_valid, o_have_value, o_pattern_error, o_seq_error;
  logic [7:0] o_accept_count;

  seg7_display_reader #(.STABLE_CYCLES(STABLE), .CHECK_SEQ(1'b1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_seg_ones(i_seg_ones), .i_seg_tens(i_seg_tens),
    .i_err_clear(i_err_clear), .o_bcd_ones(o_bcd_ones), .o_bcd_tens(o_bcd_tens),
    .o_value_valid(o_value_valid), .o_have_value(o_have_value),
    .o_accept_count(o_accept_count), .o_pattern_error(o_pattern_error),
    .o_seq_error(o_seq_error)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  logic [6:0] seg_code [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int          n_vec = 0;
  int          n_err = 0;
  logic [13:0] exp_q[$];
  logic [13:0] h_last;        // most recent sampled pattern
  int          h_run;         // how many consecutive edges it has been sampled
  logic        m_last_vld;
  logic [13:0] m_last;
  int          m_ones, m_tens, m_count;
  logic        m_vv, m_have, m_perr, m_serr;

  function automatic int digit_of(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (seg_code[i] == s) return i;
    return -1;
  endfunction

  function automatic int tens_of(input logic [6:0] s);
    int d;
    if (s == 7'h7F) return 0;
    d = digit_of(s);
    return (d == 0) ? -1 : d;
  endfunction

  task automatic model_step(input logic rst, input logic clr, input logic [13:0] cur);
    int o, t, v, old;
    logic set_p, set_s;
    if (rst) begin
      h_last = 14'h3FFF; h_run = 1; m_last_vld = 1'b0; m_last = '0;
      m_ones = 0; m_tens = 0; m_count = 0;
      m_vv = 0; m_have = 0; m_perr = 0; m_serr = 0;
      exp_q.delete();
      return;
    end
    m_vv = 1'b0; set_p = 1'b0; set_s = 1'b0;
    if (h_run == STABLE && (!m_last_vld || m_last != h_last)) begin
      m_last_vld = 1'b1;
      m_last     = h_last;
      o = digit_of(h_last[6:0]);
      t = tens_of(h_last[13:7]);
      if (o >= 0 && t >= 0) begin
        v   = t * 10 + o;
        old = m_tens * 10 + m_ones;
        if (m_have && v != 0 && v != (old + 1) % 100) set_s = 1'b1;
        m_ones = o; m_tens = t; m_vv = 1'b1; m_have = 1'b1;
        m_count = (m_count + 1) % 256;
        exp_q.push_back({7'(t), 7'(o)});
      end else begin
        set_p = 1'b1;
      end
    end
    m_perr = set_p ? 1'b1 : (clr ? 1'b0 : m_perr);
    m_serr = set_s ? 1'b1 : (clr ? 1'b0 : m_serr);
    if (cur == h_last) begin
      if (h_run <= STABLE) h_run++;
    end else begin
      h_last = cur;
      h_run  = 1;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [13:0] e;
    check("bcd_ones",      32'(o_bcd_ones),      32'(m_ones));
    check("bcd_tens",      32'(o_bcd_tens),      32'(m_tens));
    check("value_valid",   32'(o_value_valid),   32'(m_vv));
    check("have_value",    32'(o_have_value),    32'(m_have));
    check("accept_count",  32'(o_accept_count),  32'(m_count));
    check("pattern_error", 32'(o_pattern_error), 32'(m_perr));
    check("seq_error",     32'(o_seq_error),     32'(m_serr));
    if (o_value_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("accepted_value", 32'({7'(o_bcd_tens), 7'(o_bcd_ones)}), 32'(e));
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic [6:0] t, input logic [6:0] o,
                      input logic clr = 1'b0, input logic rst = 1'b0);
    i_seg_tens = t; i_seg_ones = o; i_err_clear = clr; i_rst = rst;
    @(posedge i_clk);
    model_step(rst, clr, {t, o});
    @(negedge i_clk);
    check_outputs();
  endtask

  function automatic logic [13:0] enc(input int v);
    logic [6:0] t;
    t = (v / 10 == 0) ? 7'h7F : seg_code[v / 10];
    return {t, seg_code[v % 10]};
  endfunction

  task automatic hold(input logic [13:0] p, input int n, input logic clr = 1'b0);
    for (int i = 0; i < n; i++) tick(p[13:7], p[6:0], clr);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(7'h7F, 7'h40, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v, len, kind;
    logic [13:0] p;
    i_rst = 1'b1; i_err_clear = 1'b0; i_seg_ones = 7'h40; i_seg_tens = 7'h7F;
    @(negedge i_clk);

    // T1: single 00 held
    do_reset(2);
    check("reset_count", 32'(o_accept_count), 32'(0));
    hold(enc(0), 10);
    check("t1_count", 32'(o_accept_count), 32'(1));

    // T2: count 00..12
    do_reset(2);
    for (int k = 0; k <= 12; k++) hold(enc(k), 8);
    check("t2_count", 32'(o_accept_count), 32'(13));
    check("t2_seq", 32'(o_seq_error), 32'(0));

    // T3: glitch on ones while showing 05
    do_reset(2);
    hold(enc(5), 8);
    hold({7'h7F, 7'h02}, 2);
    hold(enc(5), 8);
    check("t3_ones", 32'(o_bcd_ones), 32'(5));

    // T4: sequence break, clear, clear colliding with a new error
    hold(enc(7), 8);
    check("t4_seq_set", 32'(o_seq_error), 32'(1));
    hold(enc(7), 1, 1'b1);
    hold(enc(7), 2);
    check("t4_seq_clr", 32'(o_seq_error), 32'(0));
    hold(enc(9), 4);
    hold(enc(9), 1, 1'b1);
    check("t4_set_wins", 32'(o_seq_error), 32'(1));
    hold(enc(9), 3);

    // T5: illegal patterns
    hold({7'h7F, 7'h7F}, 8);
    hold({7'h40, 7'h40}, 8);
    hold({7'h7F, 7'h55}, 8);
    check("t5_perr", 32'(o_pattern_error), 32'(1));
    hold(enc(9), 2, 1'b1);

    // T6: wrap, then reset part-way into a new pattern
    do_reset(2);
    hold(enc(98), 8); hold(enc(99), 8); hold(enc(0), 8);
    check("t6_seq", 32'(o_seq_error), 32'(0));
    hold(enc(1), 2);
    do_reset(1);
    check("t6_rst_count", 32'(o_accept_count), 32'(0));
    hold(enc(1), 6);

    // Random traffic
    v = 1;
    for (int s = 0; s < 400; s++) begin
      len  = $urandom_range(1, 8);
      kind = $urandom_range(0, 99);
      if (kind < 1) begin
        do_reset($urandom_range(1, 2));
        continue;
      end else if (kind < 70) begin
        v = (v + 1) % 100; p = enc(v);
      end else if (kind < 80) begin
        v = $urandom_range(0, 99); p = enc(v);
      end else if (kind < 90) begin
        p = 14'($urandom);
      end else begin
        p = enc(v);
      end
      for (int i = 0; i < len; i++) tick(p[13:7], p[6:0], ($urandom_range(0, 9) == 0));
    end
    hold(enc(v), 8);
    check("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
